lcd_message_sequencer: RTL and testbench

Upstream command source for the LCD executor. Holds a 32-character, two-line message buffer written by the host. On a START pulse it issues the full refresh sequence to the executor, one command per executor ready pulse: clear, line-1 address, 16 characters, line-2 address, 16 characters, and an optional 2 s hold. It owns the executor's ENB and active-low RST pins, and re-initialises the LCD after every reset of this block.

---
 rtl/lcd_message_sequencer_if.sv | 25 ++
 rtl/lcd_message_sequencer.sv | 108 ++++++++++
 tb/tb_lcd_message_sequencer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_message_sequencer_if.sv
// Host-side buffer/control signals and executor command pins of the LCD message sequencer.
// The slave modport is the sequencer's view; the master modport is the host/executor side.
interface lcd_message_sequencer_if;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic       busy;
    logic       done;
    logic       exe_rdy;
    logic       exe_enb;
    logic       exe_rst_n;
    logic [3:0] exe_op;
    logic [7:0] exe_data;

    modport master (
        output wr_en, wr_addr, wr_data, start, exe_rdy,
        input  busy, done, exe_enb, exe_rst_n, exe_op, exe_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, exe_rdy,
        output busy, done, exe_enb, exe_rst_n, exe_op, exe_data
    );
endinterface

// File: rtl/lcd_message_sequencer.sv
// Streams a 32-character, two-line message to the LCD executor, one command per RDY pulse,
// and re-initialises the executor after every reset of this block.
module lcd_message_sequencer #(
    parameter bit WAIT_2S = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    lcd_message_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {S_INIT, S_IDLE, S_ISSUE, S_DRAIN} state_e;

    localparam logic [5:0] LAST    = WAIT_2S ? 6'd35 : 6'd34;
    localparam logic [3:0] OP_NONE = 4'd15;

    state_e     state_q, state_d;
    logic [5:0] k_q, k_d;
    logic [3:0] op_q, op_d;
    logic [7:0] data_q, data_d;
    logic       rst_n_q, rst_n_d;
    logic       done_q, done_d;
    logic       enb_q, enb_d;
    logic [7:0] cur_data;
    logic [7:0] msg_q [32];

    // Op of command k; only evaluated for k <= LAST, so k35 is the 2 s wait.
    function automatic logic [3:0] op_of(input logic [5:0] k);
        if (k == 6'd0)                    return 4'd0;
        else if (k == 6'd1 || k == 6'd18) return 4'd3;
        else if (k <= 6'd34)              return 4'd1;
        else                              return 4'd4;
    endfunction

    // Message buffer is never reset so a mid-sequence reset keeps the text.
    always_ff @(posedge clk) begin
        if (bus.wr_en) msg_q[bus.wr_addr] <= bus.wr_data;
    end

    always_comb begin
        cur_data = 8'h00;
        if (k_q >= 6'd2 && k_q <= 6'd17)       cur_data = msg_q[5'(k_q - 6'd2)];
        else if (k_q == 6'd18)                 cur_data = 8'h40;
        else if (k_q >= 6'd19 && k_q <= 6'd34) cur_data = msg_q[5'(k_q - 6'd3)];
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        op_d    = op_q;
        data_d  = data_q;
        rst_n_d = rst_n_q;
        done_d  = 1'b0;
        enb_d   = 1'b1;
        case (state_q)
            S_INIT: if (bus.exe_rdy) begin
                rst_n_d = 1'b1;
                state_d = S_IDLE;
            end
            // An RDY edge here accepts OP_NONE; START still wins and k0 shows next cycle.
            S_IDLE: if (bus.start) begin
                k_d     = 6'd0;
                op_d    = op_of(6'd0);
                state_d = S_ISSUE;
            end
            S_ISSUE: if (bus.exe_rdy) begin
                data_d = cur_data;
                k_d    = k_q + 6'd1;
                if (k_q == LAST) begin
                    op_d    = OP_NONE;
                    state_d = S_DRAIN;
                end else begin
                    op_d = op_of(k_q + 6'd1);
                end
            end
            S_DRAIN: if (bus.exe_rdy) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            k_q     <= 6'd0;
            op_q    <= OP_NONE;
            data_q  <= 8'h00;
            rst_n_q <= 1'b0;
            done_q  <= 1'b0;
            enb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            op_q    <= op_d;
            data_q  <= data_d;
            rst_n_q <= rst_n_d;
            done_q  <= done_d;
            enb_q   <= enb_d;
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_q;
    assign bus.exe_enb   = enb_q;
    assign bus.exe_rst_n = rst_n_q;
    assign bus.exe_op    = op_q;
    assign bus.exe_data  = data_q;
endmodule

// File: tb/tb_lcd_message_sequencer.sv
// Directed bench for lcd_message_sequencer: two instances (WAIT_2S=0 and 1) share stimulus
// and an executor model that pulses RDY one cycle in every ten.
module tb_lcd_message_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lcd_message_sequencer_if if0();
    lcd_message_sequencer_if if1();

    lcd_message_sequencer #(.WAIT_2S(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    lcd_message_sequencer #(.WAIT_2S(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    int vec = 0;
    int errs = 0;
    int rdy_cnt = 0;

    logic       a_rdy;
    logic [3:0] a_op [2];
    logic       a_rstn [2];
    logic [3:0] p_op [2];
    logic [7:0] p_data [2];
    logic       p_done [2], p_busy [2], p_rstn [2], p_enb [2];

    logic [3:0] ops0 [$], ops1 [$];
    logic [7:0] dat0 [$], dat1 [$];
    int done_edge0, done_edge1, done_cnt0, done_cnt1;

    function automatic logic [3:0] exp_op(input int i, input bit w);
        if (i == 0)                return 4'd0;
        else if (i == 1 || i == 18) return 4'd3;
        else if (i <= 34)          return 4'd1;
        else if (i == 35 && w)     return 4'd4;
        else                       return 4'd15;
    endfunction

    task automatic drive(input logic st, input logic we, input logic [4:0] wa, input logic [7:0] wd);
        if0.start = st;  if1.start = st;
        if0.wr_en = we;  if1.wr_en = we;
        if0.wr_addr = wa; if1.wr_addr = wa;
        if0.wr_data = wd; if1.wr_data = wd;
    endtask

    // Called at a negedge; captures what each DUT presents to the coming edge and what it shows after.
    task automatic step();
        a_rdy = (rdy_cnt == 9);
        if0.exe_rdy = a_rdy;
        if1.exe_rdy = a_rdy;
        rdy_cnt = a_rdy ? 0 : rdy_cnt + 1;
        a_op[0] = if0.exe_op;  a_op[1] = if1.exe_op;
        a_rstn[0] = if0.exe_rst_n; a_rstn[1] = if1.exe_rst_n;
        @(posedge clk);
        #1;
        p_op[0] = if0.exe_op;     p_op[1] = if1.exe_op;
        p_data[0] = if0.exe_data; p_data[1] = if1.exe_data;
        p_done[0] = if0.done;     p_done[1] = if1.done;
        p_busy[0] = if0.busy;     p_busy[1] = if1.busy;
        p_rstn[0] = if0.exe_rst_n; p_rstn[1] = if1.exe_rst_n;
        p_enb[0] = if0.exe_enb;   p_enb[1] = if1.exe_enb;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bit found = 0;
        bit busy_bad = 0;
        rst = 1'b1;
        drive(0, 0, 5'd0, 8'h00);
        if0.exe_rdy = 1'b0; if1.exe_rdy = 1'b0;
        rdy_cnt = 0;
        @(negedge clk);
        step(); step();
        vec++; if (p_busy[0] !== 1'b1) begin errs++; $display("FAIL reset_busy got %b want 1", p_busy[0]); end
        vec++; if (p_done[0] !== 1'b0) begin errs++; $display("FAIL reset_done got %b want 0", p_done[0]); end
        vec++; if (p_enb[0] !== 1'b0) begin errs++; $display("FAIL reset_enb got %b want 0", p_enb[0]); end
        vec++; if (p_rstn[0] !== 1'b0) begin errs++; $display("FAIL reset_rstn got %b want 0", p_rstn[0]); end
        vec++; if (p_op[0] !== 4'd15 || p_op[1] !== 4'd15) begin errs++; $display("FAIL reset_op got %0d/%0d want 15", p_op[0], p_op[1]); end
        vec++; if (p_data[0] !== 8'h00) begin errs++; $display("FAIL reset_data got %h want 00", p_data[0]); end
        rst = 1'b0;
        step();
        vec++; if (p_enb[0] !== 1'b1 || p_enb[1] !== 1'b1) begin errs++; $display("FAIL enb_rise got %b/%b want 1", p_enb[0], p_enb[1]); end
        for (int c = 0; c < 12 && !found; c++) begin
            step();
            if (a_rdy) found = 1;
            else if (p_busy[0] !== 1'b1) busy_bad = 1;
        end
        vec++; if (!found) begin errs++; $display("FAIL init_rdy_timeout got none want rdy edge"); end
        vec++; if (busy_bad) begin errs++; $display("FAIL init_busy got 0 want 1 before first rdy"); end
        vec++; if (a_rstn[0] !== 1'b0) begin errs++; $display("FAIL init_rstn_at_edge got %b want 0", a_rstn[0]); end
        vec++; if (p_rstn[0] !== 1'b1 || p_busy[0] !== 1'b0) begin errs++; $display("FAIL init_exit got rstn=%b busy=%b want 1/0", p_rstn[0], p_busy[0]); end
    endtask

    task automatic load_buffer();
        string a = "HELLO";
        string b = "WORLD";
        for (int i = 0; i < 32; i++) begin
            logic [7:0] ch;
            if (i % 16 >= 5) ch = 8'h20;
            else if (i < 16) ch = a[i];
            else ch = b[i - 16];
            drive(0, 1, 5'(i), ch);
            step();
        end
        drive(0, 0, 5'd0, 8'h00);
    endtask

    task automatic run_seq(input bit mid_start, input bit mid_write, input logic [7:0] exp23);
        bit ms = 0;
        bit mw = 0;
        ops0.delete(); ops1.delete(); dat0.delete(); dat1.delete();
        done_edge0 = -1; done_edge1 = -1; done_cnt0 = 0; done_cnt1 = 0;
        while (rdy_cnt == 9) step();
        drive(1, 0, 5'd0, 8'h00);
        step();
        drive(0, 0, 5'd0, 8'h00);
        vec++; if (p_busy[0] !== 1'b1 || p_op[0] !== 4'd0) begin errs++; $display("FAIL start_issue got busy=%b op=%0d want 1/0", p_busy[0], p_op[0]); end
        for (int c = 0; c < 600 && !(done_edge0 >= 0 && done_edge1 >= 0); c++) begin
            logic st, we;
            st = 0; we = 0;
            if (mid_start && !ms && ops0.size() == 5 && rdy_cnt != 9) begin st = 1; ms = 1; end
            if (mid_write && !mw && ops0.size() == 10 && rdy_cnt != 9) begin we = 1; mw = 1; end
            drive(st, we, 5'd20, 8'h41);
            step();
            if (a_rdy && done_edge0 < 0) begin ops0.push_back(a_op[0]); dat0.push_back(p_data[0]); end
            if (a_rdy && done_edge1 < 0) begin ops1.push_back(a_op[1]); dat1.push_back(p_data[1]); end
            if (p_done[0]) begin
                done_cnt0++;
                if (done_edge0 < 0) begin
                    done_edge0 = ops0.size();
                    vec++; if (p_busy[0] !== 1'b0) begin errs++; $display("FAIL done_busy0 got %b want 0", p_busy[0]); end
                end
            end
            if (p_done[1]) begin
                done_cnt1++;
                if (done_edge1 < 0) done_edge1 = ops1.size();
            end
        end
        drive(0, 0, 5'd0, 8'h00);
        vec++; if (done_edge0 != 36) begin errs++; $display("FAIL done_edge0 got %0d want 36", done_edge0); end
        vec++; if (done_edge1 != 37) begin errs++; $display("FAIL done_edge1 got %0d want 37", done_edge1); end
        vec++; if (done_cnt0 != 1 || done_cnt1 != 1) begin errs++; $display("FAIL done_count got %0d/%0d want 1/1", done_cnt0, done_cnt1); end
        for (int i = 0; i < ops0.size() && i < 36; i++) begin
            vec++; if (ops0[i] !== exp_op(i, 0)) begin errs++; $display("FAIL op0[%0d] got %0d want %0d", i, ops0[i], exp_op(i, 0)); end
        end
        for (int i = 0; i < ops1.size() && i < 37; i++) begin
            vec++; if (ops1[i] !== exp_op(i, 1)) begin errs++; $display("FAIL op1[%0d] got %0d want %0d", i, ops1[i], exp_op(i, 1)); end
        end
        vec++;
        if (dat0.size() < 36 || dat1.size() < 37) begin
            errs++; $display("FAIL data_count got %0d/%0d want 36/37", dat0.size(), dat1.size());
        end else begin
            vec++; if (dat0[1] !== 8'h00) begin errs++; $display("FAIL data_k1 got %h want 00", dat0[1]); end
            vec++; if (dat0[2] !== 8'h48) begin errs++; $display("FAIL data_k2 got %h want 48", dat0[2]); end
            vec++; if (dat0[6] !== 8'h4F) begin errs++; $display("FAIL data_k6 got %h want 4f", dat0[6]); end
            vec++; if (dat0[18] !== 8'h40) begin errs++; $display("FAIL data_k18 got %h want 40", dat0[18]); end
            vec++; if (dat0[19] !== 8'h57) begin errs++; $display("FAIL data_k19 got %h want 57", dat0[19]); end
            vec++; if (dat0[23] !== exp23 || dat1[23] !== exp23) begin errs++; $display("FAIL data_k23 got %h/%h want %h", dat0[23], dat1[23], exp23); end
            vec++; if (dat0[34] !== 8'h20) begin errs++; $display("FAIL data_k34 got %h want 20", dat0[34]); end
            vec++; if (dat1[35] !== 8'h00) begin errs++; $display("FAIL data_k35 got %h want 00", dat1[35]); end
        end
    endtask

    task automatic test_hello();
        load_buffer();
        run_seq(0, 0, 8'h44);
    endtask

    task automatic test_back_to_back();
        run_seq(1, 1, 8'h41);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        bit found = 0;
        bit busy_bad = 0;
        while (rdy_cnt == 9) step();
        drive(1, 0, 5'd0, 8'h00);
        step();
        drive(0, 0, 5'd0, 8'h00);
        for (int c = 0; c < 200 && n < 12; c++) begin
            step();
            if (a_rdy) n++;
        end
        vec++; if (n != 12) begin errs++; $display("FAIL mid_edges got %0d want 12", n); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        vec++; if (p_busy[0] !== 1'b1 || p_busy[1] !== 1'b1) begin errs++; $display("FAIL mid_rst_busy got %b/%b want 1", p_busy[0], p_busy[1]); end
        vec++; if (p_op[0] !== 4'd15 || p_rstn[0] !== 1'b0 || p_data[0] !== 8'h00) begin errs++; $display("FAIL mid_rst_state got op=%0d rstn=%b data=%h want 15/0/00", p_op[0], p_rstn[0], p_data[0]); end
        for (int c = 0; c < 12 && !found; c++) begin
            step();
            if (a_rdy) found = 1;
            else if (p_busy[0] !== 1'b1) busy_bad = 1;
        end
        vec++; if (!found) begin errs++; $display("FAIL mid_rdy_timeout got none want rdy edge"); end
        vec++; if (busy_bad) begin errs++; $display("FAIL mid_init_busy got 0 want 1"); end
        vec++; if (a_rstn[0] !== 1'b0 || a_rstn[1] !== 1'b0) begin errs++; $display("FAIL mid_rstn_at_edge got %b/%b want 0", a_rstn[0], a_rstn[1]); end
        vec++; if (a_op[0] !== 4'd15) begin errs++; $display("FAIL mid_op_at_edge got %0d want 15", a_op[0]); end
        vec++; if (p_busy[0] !== 1'b0 || p_rstn[0] !== 1'b1) begin errs++; $display("FAIL mid_idle got busy=%b rstn=%b want 0/1", p_busy[0], p_rstn[0]); end
        run_seq(0, 0, 8'h41);
    endtask

    task automatic test_start_on_rdy();
        bit found = 0;
        bit d0 = 0;
        bit d1 = 0;
        while (rdy_cnt != 9) step();
        drive(1, 0, 5'd0, 8'h00);
        step();
        drive(0, 0, 5'd0, 8'h00);
        vec++; if (a_op[0] !== 4'd15 || a_op[1] !== 4'd15) begin errs++; $display("FAIL coinc_accept got %0d/%0d want 15", a_op[0], a_op[1]); end
        vec++; if (p_op[0] !== 4'd0 || p_busy[0] !== 1'b1) begin errs++; $display("FAIL coinc_taken got op=%0d busy=%b want 0/1", p_op[0], p_busy[0]); end
        for (int c = 0; c < 12 && !found; c++) begin
            step();
            if (a_rdy) found = 1;
        end
        vec++; if (!found) begin errs++; $display("FAIL coinc_rdy_timeout got none want rdy edge"); end
        vec++; if (a_op[0] !== 4'd0 || a_op[1] !== 4'd0) begin errs++; $display("FAIL coinc_k0 got %0d/%0d want 0", a_op[0], a_op[1]); end
        vec++; if (p_op[0] !== 4'd3) begin errs++; $display("FAIL coinc_k1_next got %0d want 3", p_op[0]); end
        for (int c = 0; c < 600 && !(d0 && d1); c++) begin
            step();
            if (p_done[0]) d0 = 1;
            if (p_done[1]) d1 = 1;
        end
        vec++; if (!(d0 && d1)) begin errs++; $display("FAIL coinc_done_timeout got %b/%b want 1/1", d0, d1); end
    endtask

    initial begin
        test_reset();
        test_hello();
        test_back_to_back();
        test_reset_mid();
        test_start_on_rdy();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
